// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// tdm_pkg : shared types and constants for the 4-slot TDM receive path
// Rev 1.0
// ============================================================================
package tdm_pkg;

    localparam int SLOT_W    = 2;
    localparam int NUM_SLOTS = 4;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// tdm_slot_counter : slot index with clear / load-to-1 / increment (wraps 3->0)
// Rev 1.0
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_one,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    logic [SLOT_W-1:0] r_slot_q;
    logic [SLOT_W-1:0] w_slot_d;

    always_comb begin
        w_slot_d = r_slot_q;
        if (clear) begin
            w_slot_d = '0;
        end else if (load_one) begin
            w_slot_d = SLOT_W'(1);
        end else if (inc) begin
            w_slot_d = r_slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_q <= '0;
        end else begin
            r_slot_q <= w_slot_d;
        end
    end

    assign slot = r_slot_q;
    assign last = (r_slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// tdm_demux4 : 4-channel TDM receiver with frame alignment and sync checking
// Rev 1.0
// ============================================================================
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
);

    tdm_state_e        r_state_q;
    tdm_state_e        w_state_d;
    logic [WIDTH-1:0]  r_y_q [NUM_SLOTS];
    logic [WIDTH-1:0]  w_y_d [NUM_SLOTS];
    logic [3:0]        r_y_valid_q;
    logic [3:0]        w_y_valid_d;
    logic              r_frame_done_q;
    logic              w_frame_done_d;
    logic              r_sync_err_q;
    logic              w_sync_err_d;

    logic              w_cnt_clear;
    logic              w_cnt_load;
    logic              w_cnt_inc;
    logic [SLOT_W-1:0] w_slot;
    logic              w_last;

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_cnt_clear),
        .load_one (w_cnt_load),
        .inc      (w_cnt_inc),
        .slot     (w_slot),
        .last     (w_last)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_y_d          = r_y_q;
        w_y_valid_d    = 4'b0000;
        w_frame_done_d = 1'b0;
        w_sync_err_d   = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_inc      = 1'b0;

        if (din_valid) begin
            case (r_state_q)
                HUNT: begin
                    if (frame_sync) begin
                        w_y_d[0]    = din;
                        w_y_valid_d = 4'b0001;
                        w_cnt_load  = 1'b1;
                        w_state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // An early sync restarts the frame on this sample.
                        w_sync_err_d = (w_slot != '0);
                        w_y_d[0]     = din;
                        w_y_valid_d  = 4'b0001;
                        w_cnt_load   = 1'b1;
                    end else if (w_slot == '0) begin
                        w_sync_err_d = 1'b1;
                        w_cnt_clear  = 1'b1;
                        w_state_d    = HUNT;
                    end else begin
                        w_y_d[w_slot]       = din;
                        w_y_valid_d[w_slot] = 1'b1;
                        w_cnt_inc           = 1'b1;
                        w_frame_done_d      = w_last;
                    end
                end
                default: begin
                    w_state_d   = HUNT;
                    w_cnt_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= HUNT;
            r_y_q          <= '{default: '0};
            r_y_valid_q    <= 4'b0000;
            r_frame_done_q <= 1'b0;
            r_sync_err_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_y_q          <= w_y_d;
            r_y_valid_q    <= w_y_valid_d;
            r_frame_done_q <= w_frame_done_d;
            r_sync_err_q   <= w_sync_err_d;
        end
    end

    assign y0         = r_y_q[0];
    assign y1         = r_y_q[1];
    assign y2         = r_y_q[2];
    assign y3         = r_y_q[3];
    assign y_valid    = r_y_valid_q;
    assign frame_done = r_frame_done_q;
    assign sync_err   = r_sync_err_q;
    assign locked     = (r_state_q == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// tb_tdm_demux4 : directed self-checking bench for tdm_demux4 (WIDTH=4)
// Rev 1.0
// ============================================================================
module tb_tdm_demux4;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic [3:0]       y_valid;
    logic             frame_done;
    logic             sync_err;
    logic             locked;

    int total = 0;
    int bad   = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y_valid    (y_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_yv,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3,
                             input logic e_fd, input logic e_se, input logic e_lk);
        check({tag, ".y_valid"},    32'(y_valid),    32'(e_yv));
        check({tag, ".y0"},         32'(y0),         32'(e0));
        check({tag, ".y1"},         32'(y1),         32'(e1));
        check({tag, ".y2"},         32'(y2),         32'(e2));
        check({tag, ".y3"},         32'(y3),         32'(e3));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
        check({tag, ".sync_err"},   32'(sync_err),   32'(e_se));
        check({tag, ".locked"},     32'(locked),     32'(e_lk));
    endtask

    // Apply one input cycle, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic [3:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        // Reset with a valid sync sample present: reset must win.
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b1; frame_sync = 1'b1; din = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;

        // HUNT: unsynced samples dropped, sync without valid ignored.
        step(1'b1, 1'b0, 4'h7);
        check_all("hunt_nosync", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h7);
        check_all("hunt_sync_novalid", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Clean back-to-back frame A,B,C,D.
        step(1'b1, 1'b1, 4'hA);
        check_all("clean_s0", 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'hB);
        check_all("clean_s1", 4'b0010, 4'hA, 4'hB, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'hC);
        check_all("clean_s2", 4'b0100, 4'hA, 4'hB, 4'hC, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'hD);
        check_all("clean_s3", 4'b1000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 1'b0, 1'b1);
        idle(1);
        check_all("clean_idle", 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0, 1'b0, 1'b1);

        // Frame with 2-cycle gaps; one gap carries frame_sync without valid.
        step(1'b1, 1'b1, 4'h1);
        check_all("gap_s0", 4'b0001, 4'h1, 4'hB, 4'hC, 4'hD, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'h5);
        check_all("gap_sync_novalid", 4'b0000, 4'h1, 4'hB, 4'hC, 4'hD, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 4'h2);
        check_all("gap_s1", 4'b0010, 4'h1, 4'h2, 4'hC, 4'hD, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_all("gap_idle", 4'b0000, 4'h1, 4'h2, 4'hC, 4'hD, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'h3);
        check_all("gap_s2", 4'b0100, 4'h1, 4'h2, 4'h3, 4'hD, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 4'h4);
        check_all("gap_s3", 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1);

        // Early sync at slot 2 restarts the frame.
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b1, 4'h9);
        check_all("early_sync", 4'b0001, 4'h9, 4'h2, 4'h3, 4'h4, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 4'h6);
        check_all("early_s1", 4'b0010, 4'h9, 4'h6, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        check_all("early_s3", 4'b1000, 4'h9, 4'h6, 4'h7, 4'h8, 1'b1, 1'b0, 1'b1);

        // Missing sync after slot 3 drops to HUNT.
        step(1'b1, 1'b0, 4'h5);
        check_all("missing_sync", 4'b0000, 4'h9, 4'h6, 4'h7, 4'h8, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h3);
        check_all("hunt_ignore", 4'b0000, 4'h9, 4'h6, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hE);
        check_all("relock", 4'b0001, 4'hE, 4'h6, 4'h7, 4'h8, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4'h2);
        check_all("relock_s1", 4'b0010, 4'hE, 4'h2, 4'h7, 4'h8, 1'b0, 1'b0, 1'b1);

        // Mid-frame reset for 2 cycles discards the partial frame.
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b1; frame_sync = 1'b0; din = 4'hC;
        @(posedge clk); @(posedge clk); #1;
        check_all("mid_reset", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Slot counter must be back at 0: an unsynced sample stays in HUNT.
        step(1'b1, 1'b0, 4'hC);
        check_all("post_reset_hunt", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h3);
        check_all("post_reset_lock", 4'b0001, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
